// File: rtl/rng_pkg.sv
// Shared definitions for the RNG word arbiter: controller states and default sizing.
package rng_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        STALL = 2'd2,
        FAIL  = 2'd3
    } state_t;

    localparam int DEF_WORD_W    = 8;
    localparam int DEF_N_REQ     = 2;
    localparam int DEF_REP_LIMIT = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after the last winner.
module rr_arbiter #(
    parameter int N_REQ  = 2,
    parameter int LAST_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0]  req,
    input  logic [LAST_W-1:0] last,
    output logic [N_REQ-1:0]  gnt
);

    // Scan indices last+1, last+2, ... (wrapping) and take the first one requesting.
    always_comb begin
        int idx;
        gnt = '0;
        idx = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last) + k) % N_REQ;
            if ((gnt == '0) && req[idx]) begin
                gnt[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rng_word_arbiter.sv
// Sequences the single-bit RNG, packs accepted bits MSB-first into words, holds one
// finished word (plus one parked in the shift register while stalled) and hands words
// out through a round-robin arbiter.
// Optional feature: define RNG_HEALTH_CHECK_EN to add a repetition-count health check
// that locks the block in FAIL until reset.
module rng_word_arbiter
    import rng_pkg::*;
#(
    parameter int WORD_W    = DEF_WORD_W,
    parameter int N_REQ     = DEF_N_REQ,
    parameter int REP_LIMIT = DEF_REP_LIMIT
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rng_en,
    input  logic              bit_in,
    input  logic              bit_valid,
    input  logic [N_REQ-1:0]  req,
    output logic [N_REQ-1:0]  gnt,
    output logic [WORD_W-1:0] data_out,
    output logic              health_fail
);

    localparam int CNT_W  = $clog2(WORD_W);
    localparam int LAST_W = $clog2(N_REQ);

    state_t              state, next_state;
    logic [WORD_W-1:0]   sr, word_q, word_new;
    logic                word_valid;
    logic [CNT_W-1:0]    cnt;
    logic [LAST_W-1:0]   last, gnt_idx;
    logic [N_REQ-1:0]    req_eff;
    logic                accept, complete, grant_any, fail_hit;

    assign accept    = (state == FILL) && bit_valid;
    assign word_new  = {sr[WORD_W-2:0], bit_in};
    assign complete  = accept && (cnt == CNT_W'(WORD_W - 1));
    assign req_eff   = (word_valid && (state != FAIL)) ? req : '0;
    assign grant_any = |gnt;
    assign data_out  = grant_any ? word_q : '0;

    rr_arbiter #(
        .N_REQ  (N_REQ),
        .LAST_W (LAST_W)
    ) u_rr (
        .req  (req_eff),
        .last (last),
        .gnt  (gnt)
    );

    // Encode the one-hot grant back to an index for the round-robin pointer.
    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) gnt_idx = LAST_W'(i);
        end
    end

`ifdef RNG_HEALTH_CHECK_EN
    localparam int REP_W = $clog2(REP_LIMIT + 1);

    logic [REP_W-1:0] run_len, run_next;
    logic             last_bit;

    // Run length including the bit being accepted now; a new value restarts at 1.
    always_comb begin
        run_next = REP_W'(1);
        if ((run_len != '0) && (bit_in == last_bit)) run_next = run_len + 1'b1;
    end

    assign fail_hit = accept && (run_next == REP_W'(REP_LIMIT));

    // Track the run of identical accepted bits and latch a sticky failure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_len     <= '0;
            last_bit    <= 1'b0;
            health_fail <= 1'b0;
        end else if (accept) begin
            run_len  <= run_next;
            last_bit <= bit_in;
            if (fail_hit) health_fail <= 1'b1;
        end
    end
`else
    logic unused_rep_limit;
    assign unused_rep_limit = (REP_LIMIT == 0);
    assign fail_hit         = 1'b0;
    assign health_fail      = 1'b0;
`endif

    // State register; rng_en follows the state one cycle late except it drops at once on failure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            rng_en <= 1'b0;
        end else begin
            state  <= next_state;
            rng_en <= (state == FILL) && !fail_hit;
        end
    end

    // Next state: stall only when a word completes while the held word is still unclaimed.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = FILL;
            FILL: begin
                if (fail_hit)                                    next_state = FAIL;
                else if (complete && word_valid && !grant_any)   next_state = STALL;
            end
            STALL:   if (grant_any) next_state = FILL;
            FAIL:    next_state = FAIL;
            default: next_state = IDLE;
        endcase
    end

    // Packer, holding register and round-robin pointer; a refill on the grant edge keeps word_valid set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr         <= '0;
            cnt        <= '0;
            word_q     <= '0;
            word_valid <= 1'b0;
            last       <= LAST_W'(N_REQ - 1);
        end else begin
            if (grant_any) begin
                last       <= gnt_idx;
                word_valid <= 1'b0;
            end
            case (state)
                FILL: begin
                    if (fail_hit) begin
                        word_valid <= 1'b0;
                        cnt        <= '0;
                    end else if (accept) begin
                        if (complete) begin
                            cnt <= '0;
                            if (!word_valid || grant_any) begin
                                word_q     <= word_new;
                                word_valid <= 1'b1;
                            end else begin
                                sr <= word_new;
                            end
                        end else begin
                            sr  <= word_new;
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                STALL: begin
                    if (grant_any) begin
                        word_q     <= sr;
                        word_valid <= 1'b1;
                        cnt        <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rng_word_arbiter.sv
// Scoreboard testbench for rng_word_arbiter (WORD_W=8, N_REQ=2, REP_LIMIT=16).
// Directed bit patterns push expected grants/words; a negedge monitor pops and compares.
module tb_rng_word_arbiter;

    typedef struct packed {
        logic [1:0] gnt;
        logic [7:0] data;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       rng_en;
    logic       bit_in;
    logic       bit_valid;
    logic [1:0] req;
    logic [1:0] gnt;
    logic [7:0] data_out;
    logic       health_fail;

    exp_t exp_q[$];
    int   checks = 0;
    int   fails  = 0;

    rng_word_arbiter #(
        .WORD_W    (8),
        .N_REQ     (2),
        .REP_LIMIT (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rng_en      (rng_en),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .req         (req),
        .gnt         (gnt),
        .data_out    (data_out),
        .health_fail (health_fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Wait for the next edge, then present inputs for the edge after it.
    task automatic apply_stimulus(input logic b, input logic v);
        @(posedge clk);
        #1;
        bit_in    = b;
        bit_valid = v;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst       = 1'b1;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        req       = 2'b00;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: every granted cycle must match the oldest expected delivery.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && (gnt != 2'b00)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("[TB] FAIL scoreboard: unexpected grant gnt=%0b data=%0h at %0t", gnt, data_out, $time);
                end else begin
                    e = exp_q.pop_front();
                    check_output("sb gnt", 32'(gnt), 32'(e.gnt));
                    check_output("sb data", 32'(data_out), 32'(e.data));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [7:0] w1, w2;
        logic       b;

        rst = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; req = 2'b00;
        #1;
        rst = 1'b1;
        req = 2'b11;
        #2;
        check_output("reset rng_en", 32'(rng_en), 32'd0);
        check_output("reset gnt", 32'(gnt), 32'd0);
        check_output("reset data_out", 32'(data_out), 32'd0);
        check_output("reset health_fail", 32'(health_fail), 32'd0);

        // First word 0xB2 granted to requester 0 in the 9th cycle after release.
        $display("[TB] first word");
        do_reset();
        w1 = 8'hB2;
        exp_q.push_back('{gnt: 2'b01, data: 8'hB2});
        for (int k = 0; k <= 8; k++) begin
            apply_stimulus((k < 8) ? w1[7-k] : 1'b0, k < 8);
            req = 2'b01;
            @(negedge clk);
            check_output("t1 gnt timing", 32'(gnt), (k == 8) ? 32'd1 : 32'd0);
        end
        apply_stimulus(1'b0, 1'b0);
        @(negedge clk);
        check_output("t1 single delivery", 32'(gnt), 32'd0);
        apply_stimulus(1'b0, 1'b0);
        req = 2'b00;

        // Toggling source with both requesting: 0xAA every 8 cycles, grants alternate.
        $display("[TB] round robin");
        do_reset();
        req = 2'b11;
        for (int i = 0; i < 4; i++) exp_q.push_back('{gnt: (i % 2 == 0) ? 2'b01 : 2'b10, data: 8'hAA});
        for (int k = 0; k <= 32; k++) begin
            apply_stimulus((k < 32) ? ((k % 2) == 0) : 1'b0, k < 32);
            @(negedge clk);
            if (k > 0 && (k % 8) == 0)
                check_output("t2 gnt", 32'(gnt), ((k / 8) % 2 == 1) ? 32'd1 : 32'd2);
            else
                check_output("t2 gnt idle", 32'(gnt), 32'd0);
        end
        apply_stimulus(1'b0, 1'b0);
        req = 2'b00;

        // No requests: stall after the second word, then drain both to requester 1.
        $display("[TB] stall");
        do_reset();
        w1 = 8'h3C;
        w2 = 8'h5A;
        for (int k = 0; k <= 20; k++) begin
            b = (k < 8) ? w1[7-k] : ((k < 16) ? w2[15-k] : 1'b1);
            apply_stimulus(b, 1'b1);
            @(negedge clk);
            check_output("t3 rng_en", 32'(rng_en), (k >= 1 && k <= 16) ? 32'd1 : 32'd0);
        end
        exp_q.push_back('{gnt: 2'b10, data: 8'h3C});
        exp_q.push_back('{gnt: 2'b10, data: 8'h5A});
        apply_stimulus(1'b0, 1'b0);
        req = 2'b10;
        @(negedge clk);
        check_output("t3 gnt first", 32'(gnt), 32'd2);
        apply_stimulus(1'b0, 1'b0);
        @(negedge clk);
        check_output("t3 gnt second", 32'(gnt), 32'd2);
        apply_stimulus(1'b0, 1'b0);
        req = 2'b00;
        @(negedge clk);
        check_output("t3 resume rng_en", 32'(rng_en), 32'd1);
        check_output("t3 drained", 32'(gnt), 32'd0);

        // Word completes on the same edge the held word is granted: no stall.
        $display("[TB] refill on grant");
        do_reset();
        w1 = 8'hF0;
        w2 = 8'h0F;
        exp_q.push_back('{gnt: 2'b01, data: 8'hF0});
        exp_q.push_back('{gnt: 2'b01, data: 8'h0F});
        for (int k = 0; k <= 18; k++) begin
            b = (k < 8) ? w1[7-k] : ((k < 16) ? w2[15-k] : 1'b1);
            apply_stimulus(b, 1'b1);
            req = (k == 15 || k == 16) ? 2'b01 : 2'b00;
            @(negedge clk);
            check_output("t4 gnt", 32'(gnt), (k == 15 || k == 16) ? 32'd1 : 32'd0);
            check_output("t4 rng_en", 32'(rng_en), (k >= 1) ? 32'd1 : 32'd0);
        end
        apply_stimulus(1'b0, 1'b0);

        // Asynchronous reset with a held word and partial word: everything discarded.
        $display("[TB] reset mid-word");
        do_reset();
        w1 = 8'h81;
        for (int k = 0; k <= 12; k++) begin
            apply_stimulus((k < 8) ? w1[7-k] : 1'b1, 1'b1);
        end
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
        req       = 2'b01;
        #1;
        rst = 1'b1;
        #1;
        check_output("t5 async gnt", 32'(gnt), 32'd0);
        check_output("t5 async data", 32'(data_out), 32'd0);
        check_output("t5 async rng_en", 32'(rng_en), 32'd0);
        do_reset();
        w1 = 8'h66;
        exp_q.push_back('{gnt: 2'b01, data: 8'h66});
        for (int k = 0; k <= 8; k++) begin
            apply_stimulus((k < 8) ? w1[7-k] : 1'b0, k < 8);
            req = 2'b01;
            @(negedge clk);
            check_output("t5 fresh gnt", 32'(gnt), (k == 8) ? 32'd1 : 32'd0);
        end
        apply_stimulus(1'b0, 1'b0);
        req = 2'b00;

`ifdef RNG_HEALTH_CHECK_EN
        // Sixteen identical bits trip the health check; only reset clears it.
        $display("[TB] health check");
        do_reset();
        for (int k = 0; k <= 16; k++) begin
            apply_stimulus(1'b1, k < 16);
            @(negedge clk);
            check_output("t6 health_fail", 32'(health_fail), (k >= 16) ? 32'd1 : 32'd0);
            check_output("t6 rng_en", 32'(rng_en), (k >= 1 && k < 16) ? 32'd1 : 32'd0);
        end
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(1'b1, 1'b1);
            req = 2'b11;
            @(negedge clk);
            check_output("t6 gnt blocked", 32'(gnt), 32'd0);
            check_output("t6 sticky", 32'(health_fail), 32'd1);
        end
        do_reset();
        #1;
        check_output("t6 cleared", 32'(health_fail), 32'd0);
`else
        check_output("health_fail tied low", 32'(health_fail), 32'd0);
`endif

        repeat (3) @(posedge clk);
        check_output("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/rng_word_arbiter.md
# rng_word_arbiter

Controller that sequences the single-bit RNG source and shares its output between several requesters. It enables the RNG, packs accepted bits into WORD_W-bit words, holds one finished word, and hands it out through a round-robin request/grant arbiter. It sits directly downstream of the rng block's bit_out and is the only consumer of it.

## Interface
- WORD_W, 8, bits per delivered word (≥2)
- N_REQ, 2, number of requesters (≥2)
- REP_LIMIT, 16, consecutive identical bits that trip the health check (only with RNG_HEALTH_CHECK_EN)

- clk  in  1  clock; all logic on posedge
- rst  in  1  asynchronous, active-high reset
- rng_en  out  1  enable to RNG source; registered
- bit_in  in  1  RNG bit (rng bit_out)
- bit_valid  in  1  bit_in is valid this cycle
- req  in  N_REQ  per-requester request; held high until granted
- gnt  out  N_REQ  one-hot grant, one-cycle pulse
- data_out  out  WORD_W  word delivered; valid only in cycles where gnt≠0
- health_fail  out  1  sticky RNG health failure flag

## Operation
- Reset values: state=IDLE, rng_en=0, shift reg sr=0, bit count cnt=0, word_q=0, word_valid=0, rr pointer last=N_REQ-1, gnt=0, data_out=0, health_fail=0.
- FSM states: IDLE, FILL, STALL, FAIL (FAIL only with macro).
  - IDLE → FILL unconditionally on first edge after reset release.
  - FILL: rng_en=1. Bit accepted iff bit_valid: sr <= {sr[WORD_W-2:0], bit_in}, cnt++. First accepted bit ends up as MSB.
  - Word completes on accepting bit with cnt==WORD_W-1: if word_valid==0 or word_q granted same cycle → word_q <= completed word, word_valid=1, cnt=0, stay FILL. Otherwise → STALL, sr holds full word.
  - STALL: rng_en=0; bit_valid ignored. On edge where word_q is granted: word_q <= sr, word_valid stays 1, cnt=0, → FILL.
- Arbiter: gnt combinational from word_valid, req, last. If word_valid and req≠0, grant the first requesting index after last (wrapping mod N_REQ); data_out=word_q in that cycle, else 0. On that edge last <= granted index; word_valid clears unless refilled the same edge.
- Each word delivered exactly once; no word dropped except by reset or FAIL.
- Requester deasserting req before gnt is legal; it simply loses its turn.

## Timing
- gnt is same-cycle with req when word_valid=1 (zero-latency grant from registered word_q).
- rng_en is registered: reflects state, so it drops the cycle after entering STALL; RNG may present one more bit_valid, which is ignored.
- First word available: edge after WORD_W-th accepted bit; with bit_valid continuously 1, word_valid rises WORD_W+1 cycles after reset release (1 IDLE cycle + WORD_W bits).
- Back-to-back: continuous req and bit_valid gives one word every WORD_W cycles.
- Reset mid-operation: partial sr, word_q and pending grants discarded immediately (async), gnt=0 combinationally.

## Configuration
- RNG_HEALTH_CHECK_EN defined: repetition counter tracks run length of identical accepted bits (first bit = run 1). When run reaches REP_LIMIT → FAIL on that edge: health_fail=1 (sticky until rst), rng_en=0, word_valid=0, cnt=0, gnt held 0. Only rst leaves FAIL.
- Not defined: no counter, no FAIL state, health_fail tied 0.

## Structure
- Shared package rng_pkg: state enum (IDLE, FILL, STALL, FAIL), default WORD_W/N_REQ/REP_LIMIT constants.
- One sub-module: rr_arbiter (N_REQ req, last pointer in, one-hot gnt out, pure combinational) instantiated once; FSM, packer and health check live in rng_word_arbiter.

## Test plan
- Reset release, bit_valid=1, bits 1,0,1,1,0,0,1,0, req=2'b01 → word_valid after 9 cycles, gnt=2'b01 same cycle, data_out=0xB2.
- Toggling source (1,0,1,0…) continuous, req=2'b11 held → gnts alternate 01,10,01… starting with 01, each data_out=0xAA, one per 8 cycles.
- No req for 20 cycles with continuous bits → STALL after second word, rng_en=0 next cycle; then req=2'b10 → 0x first word, next cycle second word available, FILL resumes.
- Word completes on same edge word_q is granted → no STALL, next word loaded, rng_en stays 1.
- rst asserted mid-word (cnt=5) with word_valid=1 → all outputs to reset values immediately; next word built from fresh bits only.
- With RNG_HEALTH_CHECK_EN, REP_LIMIT=16: 16 consecutive 1 bits → health_fail=1 on 16th accepted bit edge, rng_en=0, gnt never asserts despite req=2'b11; cleared only by rst.
